// File: rtl/axi_sram_slv.sv
// axi_sram_slv: AXI4 slave backed by an on-chip word-addressed SRAM.
// Read and write channels are handled by independent FSMs with one
// outstanding transaction each. FIXED/INCR bursts up to 256 beats, byte
// strobes, programmable read latency and per-beat error responses.
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   aw*_i / awready_o              write address channel
//   w*_i  / wready_o               write data channel
//   bvalid_o, bresp_o, bid_o / bready_i   write response channel
//   ar*_i / arready_o              read address channel
//   rvalid_o, rdata_o, rresp_o, rlast_o, rid_o / rready_i  read data channel
`timescale 1ns/1ps
module axi_sram_slv #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MEM_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE      = 32'h8000_0000,
  parameter int unsigned       RD_LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic [3:0]        awid_i,
  input  logic [7:0]        awlen_i,
  input  logic [2:0]        awsize_i,
  input  logic [1:0]        awburst_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wlast_i,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic [1:0]        bresp_o,
  output logic [3:0]        bid_o,
  input  logic              arvalid_i,
  output logic              arready_o,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic [3:0]        arid_i,
  input  logic [7:0]        arlen_i,
  input  logic [2:0]        arsize_i,
  input  logic [1:0]        arburst_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic [3:0]        rid_o
);

  localparam int unsigned       IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] LIM_B = ADDR_W'(4 * MEM_WORDS);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Response encodings are ordered by severity, so "worst" is a plain max.
  function automatic logic [1:0] f_worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  // ---------------- write channel ----------------
  logic [1:0]        r_wstate;
  logic              r_awready, r_wready, r_bvalid;
  logic [1:0]        r_bresp, r_werr;
  logic [3:0]        r_bid, r_wid;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wlen;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst;
  logic [8:0]        r_wcnt;

  logic              w_aw_hs, w_w_hs, w_b_hs;
  logic [ADDR_W-1:0] w_woff;
  logic              w_win, w_wbad, w_wlast_beat, w_wr_en;
  logic [IDX_W-1:0]  w_widx;
  logic [1:0]        w_wbeat_resp;

  assign w_aw_hs      = awvalid_i & r_awready;
  assign w_w_hs       = wvalid_i & r_wready;
  assign w_b_hs       = r_bvalid & bready_i;
  // Offset from BASE wraps modulo 2^ADDR_W, so one unsigned compare covers
  // addresses both below BASE and beyond the top of the SRAM.
  assign w_woff       = r_waddr - BASE;
  assign w_win        = (w_woff < LIM_B);
  assign w_widx       = w_woff[IDX_W+1:2];
  assign w_wbad       = (r_wsize != 3'b010) | r_wburst[1];
  assign w_wlast_beat = (r_wcnt == {1'b0, r_wlen});
  assign w_wr_en      = w_w_hs & w_win & ~w_wbad;

  always_comb begin
    w_wbeat_resp = RESP_OKAY;
    if (w_wbad || (wlast_i != w_wlast_beat)) w_wbeat_resp = RESP_SLVERR;
    if (!w_win) w_wbeat_resp = RESP_DECERR;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_bid     <= '0;
      r_werr    <= '0;
      r_wid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_wcnt    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_waddr   <= awaddr_i;
            r_wid     <= awid_i;
            r_wlen    <= awlen_i;
            r_wsize   <= awsize_i;
            r_wburst  <= awburst_i;
            r_wcnt    <= '0;
            r_werr    <= RESP_OKAY;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_werr <= f_worse(r_werr, w_wbeat_resp);
            r_wcnt <= r_wcnt + 9'd1;
            if (r_wburst == 2'b01) r_waddr <= r_waddr + STEP;
            if (w_wlast_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= f_worse(r_werr, w_wbeat_resp);
              r_bid    <= r_wid;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_i[b]) r_mem[w_widx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  logic [1:0]        r_rstate;
  logic              r_arready, r_rvalid, r_rlast;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic [3:0]        r_rid_o, r_rid;
  logic [ADDR_W-1:0] r_raddr;   // address of the next beat to be loaded
  logic [7:0]        r_rlen;
  logic [2:0]        r_rsize;
  logic [1:0]        r_rburst;
  logic [8:0]        r_rcnt;    // index of the beat currently presented
  logic [7:0]        r_rlat;

  logic              w_ar_hs, w_r_hs, w_rin, w_rbad;
  logic [ADDR_W-1:0] w_roff, w_rnext;
  logic [IDX_W-1:0]  w_ridx;
  logic [1:0]        w_rbeat_resp;
  logic [DATA_W-1:0] w_rbeat_data;

  assign w_ar_hs = arvalid_i & r_arready;
  assign w_r_hs  = r_rvalid & rready_i;
  assign w_roff  = r_raddr - BASE;
  assign w_rin   = (w_roff < LIM_B);
  assign w_ridx  = w_roff[IDX_W+1:2];
  assign w_rbad  = (r_rsize != 3'b010) | r_rburst[1];
  assign w_rnext = (r_rburst == 2'b01) ? r_raddr + STEP : r_raddr;

  always_comb begin
    w_rbeat_resp = RESP_OKAY;
    w_rbeat_data = '0;
    if (!w_rin)      w_rbeat_resp = RESP_DECERR;
    else if (w_rbad) w_rbeat_resp = RESP_SLVERR;
    else             w_rbeat_data = r_mem[w_ridx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rid_o   <= '0;
      r_rid     <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rcnt    <= '0;
      r_rlat    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_raddr   <= araddr_i;
            r_rid     <= arid_i;
            r_rlen    <= arlen_i;
            r_rsize   <= arsize_i;
            r_rburst  <= arburst_i;
            r_rcnt    <= '0;
            r_rlat    <= 8'(RD_LAT - 1);
            r_arready <= 1'b0;
            r_rstate  <= R_WAIT;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_rlat == 8'd0) begin
            r_rdata  <= w_rbeat_data;
            r_rresp  <= w_rbeat_resp;
            r_rid_o  <= r_rid;
            r_rlast  <= (r_rlen == 8'd0);
            r_rvalid <= 1'b1;
            r_raddr  <= w_rnext;
            r_rstate <= R_DATA;
          end else begin
            r_rlat <= r_rlat - 8'd1;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rcnt  <= r_rcnt + 9'd1;
              r_rdata <= w_rbeat_data;
              r_rresp <= w_rbeat_resp;
              r_rlast <= ((r_rcnt + 9'd1) == {1'b0, r_rlen});
              r_raddr <= w_rnext;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign awready_o = r_awready;
  assign wready_o  = r_wready;
  assign bvalid_o  = r_bvalid;
  assign bresp_o   = r_bresp;
  assign bid_o     = r_bid;
  assign arready_o = r_arready;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;
  assign rlast_o   = r_rlast;
  assign rid_o     = r_rid_o;

endmodule

// File: tb/tb_axi_sram_slv.sv
`timescale 1ns/1ps
module tb_axi_sram_slv;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_WORDS = 4096;
  localparam int unsigned RD_LAT    = 1;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam logic [31:0] LIM       = 32'(4 * MEM_WORDS);
  localparam int unsigned TMO       = 200;

  logic        clk, rst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  axi_sram_slv #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS),
                 .BASE(BASE), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awid_i(awid),
    .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp), .bid_o(bid),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arid_i(arid),
    .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .rlast_o(rlast), .rid_o(rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: sparse word store, unwritten bytes are X.
  logic [31:0] mdl [int unsigned];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [3:0]  rd_id   [256];

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input int unsigned i);
    return (burst == 2'b01) ? a + 32'(4 * i) : a;
  endfunction
  function automatic bit in_mem(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < LIM;
  endfunction
  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction
  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                           output logic [1:0] got_resp, output logic [3:0] got_id);
    int unsigned cyc;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
    cyc = 0;
    while (!awready && cyc < TMO) begin @(negedge clk); cyc++; end
    if (cyc >= TMO) check_eq("aw_timeout", 64'(awready), 64'(1));
    @(negedge clk);
    awvalid = 1'b0;
    for (int unsigned i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast = (i == len) ^ (int'(i) == bad_last);
      cyc = 0;
      while (!wready && cyc < TMO) begin @(negedge clk); cyc++; end
      if (cyc >= TMO) check_eq("w_timeout", 64'(wready), 64'(1));
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    cyc = 0;
    while (!bvalid && cyc < TMO) begin @(negedge clk); cyc++; end
    if (cyc >= TMO) check_eq("b_timeout", 64'(bvalid), 64'(1));
    got_resp = bresp; got_id = bid;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check_eq("b_hold", 64'({bvalid, bid, bresp}), 64'({1'b1, got_id, got_resp}));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_eq("b_done", 64'({bvalid, awready}), 64'({1'b0, 1'b1}));
  endtask

  // mode: 0 = rready always high, 1 = toggling, 2 = random.
  // abort >= 0 returns while beat 'abort' is presented, before it is accepted.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int unsigned mode, input int abort, output int unsigned n);
    int unsigned cyc;
    bit held;
    logic [63:0] hv;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    cyc = 0;
    while (!arready && cyc < TMO) begin @(negedge clk); cyc++; end
    if (cyc >= TMO) check_eq("ar_timeout", 64'(arready), 64'(1));
    @(negedge clk);
    arvalid = 1'b0;
    check_eq("r_lat_early", 64'(rvalid), 64'(0));
    repeat (RD_LAT) @(negedge clk);
    check_eq("r_lat", 64'(rvalid), 64'(1));
    n = 0; cyc = 0; held = 1'b0; hv = '0;
    while (n <= len && cyc < 2000) begin
      if (int'(n) == abort) return;
      case (mode)
        0:       rready = 1'b1;
        1:       rready = ~cyc[0];
        default: rready = 1'($urandom_range(0, 1));
      endcase
      check_eq("r_valid", 64'(rvalid), 64'(1));
      if (held) check_eq("r_hold", {rdata, 25'd0, rresp, rlast, rid}, hv);
      if (rvalid && rready) begin
        rd_data[n] = rdata; rd_resp[n] = rresp; rd_last[n] = rlast; rd_id[n] = rid;
        n++;
        held = 1'b0;
      end else begin
        held = rvalid;
        hv = {rdata, 25'd0, rresp, rlast, rid};
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (n <= len) check_eq("r_timeout", 64'(n), 64'(len) + 64'(1));
    check_eq("r_done", 64'({rvalid, arready}), 64'({1'b0, 1'b1}));
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input int bad_last);
    logic [1:0]  exp_resp, got_resp;
    logic [3:0]  got_id;
    logic [31:0] a, t;
    int unsigned w;
    bit bad;
    bad = (size != 3'b010) || burst[1];
    exp_resp = 2'b00;
    for (int unsigned i = 0; i <= len; i++) begin
      a = beat_addr(addr, burst, i);
      if (!in_mem(a)) exp_resp = worse(exp_resp, 2'b11);
      else if (bad) exp_resp = worse(exp_resp, 2'b10);
      else begin
        w = widx(a);
        t = mdl.exists(w) ? mdl[w] : 'x;
        for (int b = 0; b < 4; b++) if (ws[i][b]) t[8*b +: 8] = wd[i][8*b +: 8];
        mdl[w] = t;
      end
      if (int'(i) == bad_last) exp_resp = worse(exp_resp, 2'b10);
    end
    axi_write(addr, id, len, size, burst, bad_last, got_resp, got_id);
    check_eq({tag, "_bresp"}, 64'(got_resp), 64'(exp_resp));
    check_eq({tag, "_bid"}, 64'(got_id), 64'(id));
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                         input int unsigned mode);
    int unsigned n;
    logic [31:0] a, exp_d;
    logic [1:0]  exp_r;
    bit bad;
    axi_read(addr, id, len, size, burst, mode, -1, n);
    bad = (size != 3'b010) || burst[1];
    for (int unsigned i = 0; i < n; i++) begin
      a = beat_addr(addr, burst, i);
      exp_r = !in_mem(a) ? 2'b11 : (bad ? 2'b10 : 2'b00);
      if (exp_r != 2'b00) exp_d = '0;
      else exp_d = mdl.exists(widx(a)) ? mdl[widx(a)] : 'x;
      if (!$isunknown(exp_d)) check_eq($sformatf("%s_d%0d", tag, i), 64'(rd_data[i]), 64'(exp_d));
      check_eq($sformatf("%s_r%0d", tag, i), 64'(rd_resp[i]), 64'(exp_r));
      check_eq($sformatf("%s_l%0d", tag, i), 64'(rd_last[i]), 64'(i == len));
      check_eq($sformatf("%s_i%0d", tag, i), 64'(rd_id[i]), 64'(id));
    end
  endtask

  task automatic fill_rand(input int unsigned len, input bit full_strb);
    for (int unsigned i = 0; i <= len; i++) begin
      wd[i] = $urandom;
      ws[i] = full_strb ? 4'hF : 4'($urandom);
    end
  endtask

  initial begin
    int unsigned nb;
    rst = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'({awready, wready, arready}), 64'(0));
    check_eq("rst_valid", 64'({bvalid, rvalid, rlast}), 64'(0));
    check_eq("rst_payload", {rdata, 20'd0, rresp, rid, bresp, bid}, 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_ready", 64'({awready, arready}), 64'({1'b1, 1'b1}));

    // Initialise words 0..79 so later random reads have known data.
    fill_rand(79, 1'b1);
    do_write("init", BASE, 4'h1, 8'd79, 3'b010, 2'b01, -1);

    // Single beat write/read.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write("single", 32'h8000_0010, 4'h3, 8'd0, 3'b010, 2'b01, -1);
    do_read("single", 32'h8000_0010, 4'h5, 8'd0, 3'b010, 2'b01, 0);

    // INCR burst, read back with toggling rready.
    for (int unsigned i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write("incr", 32'h8000_0100, 4'h7, 8'd3, 3'b010, 2'b01, -1);
    do_read("incr", 32'h8000_0100, 4'h9, 8'd3, 3'b010, 2'b01, 1);

    // Partial strobe merge.
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write("pstrb0", 32'h8000_0020, 4'h2, 8'd0, 3'b010, 2'b01, -1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write("pstrb1", 32'h8000_0020, 4'h2, 8'd0, 3'b010, 2'b01, -1);
    do_read("pstrb", 32'h8000_0020, 4'h4, 8'd0, 3'b010, 2'b01, 0);

    // Out of range, wrap-around, last-word boundary.
    do_read("oor", BASE + LIM, 4'hA, 8'd1, 3'b010, 2'b01, 2);
    fill_rand(1, 1'b1);
    do_write("oor", BASE + LIM, 4'hB, 8'd1, 3'b010, 2'b01, -1);
    do_read("alias0", BASE, 4'hC, 8'd1, 3'b010, 2'b01, 0);
    fill_rand(3, 1'b1);
    do_write("wrap", 32'hFFFF_FFF8, 4'h1, 8'd3, 3'b010, 2'b01, -1);
    do_read("wrap", 32'hFFFF_FFF8, 4'h1, 8'd3, 3'b010, 2'b01, 0);
    do_read("below", BASE - 32'd4, 4'h6, 8'd1, 3'b010, 2'b01, 0);
    fill_rand(1, 1'b1);
    do_write("edge", BASE + LIM - 32'd4, 4'hE, 8'd1, 3'b010, 2'b01, -1);
    do_read("edge", BASE + LIM - 32'd4, 4'hD, 8'd1, 3'b010, 2'b01, 0);

    // Protocol errors: wlast low on final beat, early wlast, bad size, WRAP.
    fill_rand(1, 1'b1);
    do_write("wlast_lo", 32'h8000_0040, 4'h8, 8'd1, 3'b010, 2'b01, 1);
    do_read("wlast_lo", 32'h8000_0040, 4'h8, 8'd1, 3'b010, 2'b01, 0);
    fill_rand(1, 1'b1);
    do_write("wlast_hi", 32'h8000_0048, 4'h8, 8'd1, 3'b010, 2'b01, 0);
    fill_rand(0, 1'b1);
    do_write("size1", 32'h8000_0050, 4'h9, 8'd0, 3'b001, 2'b01, -1);
    do_read("size1", 32'h8000_0050, 4'h9, 8'd0, 3'b010, 2'b01, 0);
    do_read("size1r", 32'h8000_0050, 4'h9, 8'd0, 3'b001, 2'b01, 0);
    fill_rand(2, 1'b1);
    do_write("wrapb", 32'h8000_0060, 4'h3, 8'd2, 3'b010, 2'b10, -1);
    do_read("wrapb", 32'h8000_0060, 4'h3, 8'd2, 3'b010, 2'b10, 2);

    // FIXED burst: all beats hit the same word.
    fill_rand(3, 1'b0);
    do_write("fixed", 32'h8000_0014, 4'h5, 8'd3, 3'b010, 2'b00, -1);
    do_read("fixed", 32'h8000_0014, 4'h5, 8'd2, 3'b010, 2'b00, 2);

    // 256-beat burst.
    fill_rand(255, 1'b1);
    do_write("len255", BASE + 32'd512, 4'hF, 8'd255, 3'b010, 2'b01, -1);
    do_read("len255", BASE + 32'd512, 4'hF, 8'd255, 3'b010, 2'b01, 0);

    // Randomised traffic over the initialised window.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] ra;
      logic [7:0]  rl;
      logic [1:0]  rb;
      logic [2:0]  rs;
      ra = BASE + 32'(4 * $urandom_range(0, 79)) + 32'($urandom_range(0, 3));
      rl = 8'($urandom_range(0, 15));
      rb = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      rs = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
      if ($urandom_range(0, 1) == 1) begin
        fill_rand(rl, $urandom_range(0, 1) == 1);
        do_write("rnd_w", ra, 4'($urandom), rl, rs, rb,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rl)) : -1);
      end else begin
        do_read("rnd_r", ra, 4'($urandom), rl, rs, rb, $urandom_range(0, 2));
      end
    end

    // Reset in the middle of a len=7 read, while beat 2 is presented.
    axi_read(BASE, 4'h2, 8'd7, 3'b010, 2'b01, 0, 1, nb);
    check_eq("abort_beats", 64'(nb), 64'(1));
    rst = 1'b1;
    rready = 1'b0;
    #1;
    check_eq("abort_rvalid", 64'(rvalid), 64'(0));
    check_eq("abort_arready", 64'(arready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_arready0", 64'(arready), 64'(0));
    @(negedge clk);
    check_eq("rel_arready1", 64'({arready, awready, rvalid}), 64'({1'b1, 1'b1, 1'b0}));
    do_read("post_rst", BASE, 4'h6, 8'd7, 3'b010, 2'b01, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=%0d exp=0", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_sram_slv.md
Name: axi_sram_slv

Overview:
AXI4 slave responder that terminates the core's AXI master port and backs it with an on-chip word-addressed SRAM. It serves as the memory model and simulation target for the core's interconnect master. Read and write channels run independent state machines, each with one outstanding transaction. The block supports FIXED and INCR bursts up to 256 beats, byte strobes, configurable read latency, and per-beat error responses.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (only 32 supported; 4 bytes/beat)
MEM_WORDS, 4096, SRAM depth in 32-bit words; valid byte range is [BASE, BASE+4*MEM_WORDS)
BASE, 32'h8000_0000, byte address of word 0
RD_LAT, 1, cycles from AR acceptance to first R beat valid (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
awvalid_i in 1; awready_o out 1; awaddr_i in ADDR_W; awid_i in 4; awlen_i in 8; awsize_i in 3; awburst_i in 2  (AW channel)
wvalid_i in 1; wready_o out 1; wdata_i in DATA_W; wstrb_i in 4; wlast_i in 1  (W channel)
bvalid_o out 1; bready_i in 1; bresp_o out 2; bid_o out 4  (B channel)
arvalid_i in 1; arready_o out 1; araddr_i in ADDR_W; arid_i in 4; arlen_i in 8; arsize_i in 3; arburst_i in 2  (AR channel)
rvalid_o out 1; rready_i in 1; rdata_o out DATA_W; rresp_o out 2; rlast_o out 1; rid_o out 4  (R channel)

Behaviour:
- Reset: all *ready_o/*valid_o=0, bresp/rresp/bid/rid/rdata/rlast=0; both FSMs go to IDLE. SRAM contents are not reset. Assertion mid-burst aborts the transaction with no response.
- Handshake: transfer occurs when valid && ready on a rising edge. Once asserted, bvalid_o, rvalid_o and their payloads hold stable until ready.
- Write FSM:
  - W_IDLE: awready_o=1. On AW handshake, latch addr/id/len/size/burst, clear beat counter and error, go to W_DATA.
  - W_DATA: awready_o=0, wready_o=1. Each W handshake writes the bytes enabled by wstrb to the current word, provided that beat is legal. Address advances +4 for INCR and holds for FIXED. After beat awlen+1, go to W_RESP.
  - W_RESP: bvalid_o=1, bid_o=latched id, bresp_o=worst error seen. On B handshake, return to W_IDLE (awready reasserts next cycle).
- Read FSM:
  - R_IDLE: arready_o=1. On AR handshake, latch fields, load latency counter with RD_LAT-1, go to R_WAIT.
  - R_WAIT: count down; at 0, register word into rdata_o, raise rvalid_o, go to R_DATA. With RD_LAT=1, the first beat is valid the cycle after AR acceptance.
  - R_DATA: rvalid_o=1, rlast_o=1 only on beat arlen+1. On R handshake of a non-last beat, the next beat is valid the following cycle (1 beat/cycle at full rready). On the last beat, go to R_IDLE.
- Error rules (per beat; rresp per beat, bresp is max over beats, severity DECERR>SLVERR>OKAY):
  - Word index outside MEM_WORDS: DECERR 2'b11, write suppressed, rdata=0.
  - size!=3'b010 or burst==WRAP/reserved: SLVERR 2'b10 for the whole transaction, no writes, rdata=0; beats are still counted and consumed.
  - wlast_i mismatch (high before final beat, or low on final beat): SLVERR. Termination follows awlen only.
- Misaligned addr[1:0]!=0: treated as aligned (low bits ignored), OKAY.
- Simultaneous read and write of the same word in the same cycle: the read returns old data and the write completes.
- Address arithmetic wraps modulo 2^ADDR_W. A wrapped address is checked for range like any other.
- awlen/arlen=255 (256 beats) is supported; the beat counter is 9 bits.

Test Plan:
- Single write AW addr=0x8000_0010 len=0 wdata=0xDEADBEEF wstrb=F, then read same address -> bresp=00, rdata=0xDEADBEEF, rlast=1, rresp=00, rid=arid.
- INCR write len=3 at 0x8000_0100 data 1,2,3,4, then INCR read len=3 with rready toggling 1/0 -> R beats 1,2,3,4 in order, held stable while stalled, rlast only on 4th.
- Partial strobe: word=0x11223344, write 0xAABBCCDD wstrb=4'b0101 -> reads 0x11BB33DD.
- Out of range: read at BASE+4*MEM_WORDS len=1 -> two beats rresp=11, rdata=0; write there -> bresp=11, memory unchanged.
- wlast low on final beat of len=1 write -> bresp=10, data written; awsize=1 write -> bresp=10, no write.
- Assert rst_i during beat 2 of a len=7 read -> rvalid=0 immediately, arready=1 one cycle after release, new read returns correct data.
